// File: rtl/y_window_pkg.sv
// Shared constants and types for the vertical 5-tap Gaussian stage.
// Default coefficients sum to COEF_SUM, so the output is the sum shifted right by OUT_SHIFT.
package y_window_pkg;

   localparam int PIX_W     = 8;
   localparam int H0_DEF    = 6;
   localparam int H1_DEF    = 58;
   localparam int H2_DEF    = 128;
   localparam int COEF_SUM  = 256;
   localparam int OUT_SHIFT = 8;
   localparam int PROD_W    = 15;
   localparam int SUM_W     = 16;

   // Row warm-up: count completed lines until all four line buffers hold real data
   typedef enum logic [2:0] {
      ROW_0,
      ROW_1,
      ROW_2,
      ROW_3,
      ROW_FULL
   } row_state_t;

   function automatic logic [PROD_W-1:0] tap_mul(input logic [PIX_W-1:0] px,
                                                 input logic [PIX_W-1:0] coef);
      return PROD_W'({8'b0, px} * {8'b0, coef});
   endfunction

endpackage

// File: rtl/y_line_buffer.sv
// One image line of pixel storage: synchronous write, combinational read at the same address,
// so a read-then-write on one edge returns the previous line's pixel.
module y_line_buffer
   import y_window_pkg::*;
#(
   parameter int WIDTH = 640,
   parameter int COLW  = 10
) (
   input  logic             clock,
   input  logic             we,
   input  logic [COLW-1:0]  addr,
   input  logic [PIX_W-1:0] wdata,
   output logic [PIX_W-1:0] rdata
);

   logic [PIX_W-1:0] mem [WIDTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/y_window.sv
// Vertical 5-tap Gaussian: four cascaded line buffers feed a free-running 3-stage
// multiply/add pipeline; validout marks outputs once four full lines have been seen.
module y_window
   import y_window_pkg::*;
#(
   parameter int WIDTH = 640,
   parameter int h0    = H0_DEF,
   parameter int h1    = H1_DEF,
   parameter int h2    = H2_DEF,
   parameter int COLW  = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [PIX_W-1:0] din,
   input  logic             validin,
   output logic [PIX_W-1:0] dout,
   output logic             validout
);

   localparam logic [PIX_W-1:0] C0 = PIX_W'(h0);
   localparam logic [PIX_W-1:0] C1 = PIX_W'(h1);
   localparam logic [PIX_W-1:0] C2 = PIX_W'(h2);

   logic [COLW-1:0]           col;
   logic                      last_col;
   row_state_t                row, row_next;
   logic [4:0][PIX_W-1:0]     tap;
   logic                      v0, v1, v2;
   logic [PROD_W-1:0]         p0, p1, p2, p3, p4;
   logic [SUM_W-1:0]          a, b, c;
   logic [SUM_W-1:0]          sum;

   assign last_col = (col == COLW'(WIDTH - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col <= '0;
      end else if (validin) begin
         col <= last_col ? '0 : col + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         row <= ROW_0;
      end else begin
         row <= row_next;
      end
   end

   always_comb begin
      row_next = row;
      if (validin && last_col) begin
         unique case (row)
            ROW_0:    row_next = ROW_1;
            ROW_1:    row_next = ROW_2;
            ROW_2:    row_next = ROW_3;
            ROW_3:    row_next = ROW_FULL;
            ROW_FULL: row_next = ROW_FULL;
            default:  row_next = ROW_0;
         endcase
      end
   end

   // tap[k] is row r-k; each buffer is written with the line it just read from its predecessor
   assign tap[0] = din;

   for (genvar k = 1; k < 5; k++) begin : g_lb
      y_line_buffer #(
         .WIDTH(WIDTH),
         .COLW (COLW)
      ) u_lb (
         .clock(clock),
         .we   (validin),
         .addr (col),
         .wdata(tap[k-1]),
         .rdata(tap[k])
      );
   end

   assign v0 = validin && (row == ROW_FULL);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         p0 <= '0;
         p1 <= '0;
         p2 <= '0;
         p3 <= '0;
         p4 <= '0;
         v1 <= 1'b0;
      end else begin
         p0 <= tap_mul(tap[0], C0);
         p1 <= tap_mul(tap[1], C1);
         p2 <= tap_mul(tap[2], C2);
         p3 <= tap_mul(tap[3], C1);
         p4 <= tap_mul(tap[4], C0);
         v1 <= v0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         a  <= '0;
         b  <= '0;
         c  <= '0;
         v2 <= 1'b0;
      end else begin
         a  <= SUM_W'(p0) + SUM_W'(p4);
         b  <= SUM_W'(p1) + SUM_W'(p3);
         c  <= SUM_W'(p2);
         v2 <= v1;
      end
   end

   assign sum = a + b + c;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dout     <= '0;
         validout <= 1'b0;
      end else begin
         dout     <= sum[OUT_SHIFT +: PIX_W];
         validout <= v2;
      end
   end

endmodule

// File: tb/tb_y_window.sv
// Bench for y_window at WIDTH=8: table-driven images, reset corner case and a random
// stream checked against a whole-image reference model.
module tb_y_window;

   localparam int W = 8;

   logic       clock;
   logic       reset;
   logic [7:0] din;
   logic       validin;
   logic [7:0] dout;
   logic       validout;

   y_window #(
      .WIDTH(W),
      .COLW (3)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .din     (din),
      .validin (validin),
      .dout    (dout),
      .validout(validout)
   );

   typedef struct {
      int id;
      int nrows;
      bit gap;
      bit ramp;
      int rowv[9];
      int expv[5];
   } vec_t;

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   vec_t  vecs[5];
   exp_t  exp_q[$];
   int    hist[$];
   int    cyc;
   int    total;
   int    bad;
   int    cur_id;
   bit    mon_en;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc = cyc + 1;

   // Every negedge: an output is due exactly when an input was captured two edges ago
   always @(negedge clock) begin
      if (mon_en) begin
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 2) begin
            total++;
            if (validout !== 1'b1 || dout !== 8'(exp_q[0].val)) begin
               bad++;
               $display("FAIL out case=%0d cyc=%0d: validout=%b dout=%0d, want validout=1 dout=%0d",
                        cur_id, cyc, validout, dout, exp_q[0].val);
            end
            void'(exp_q.pop_front());
         end else begin
            total++;
            if (validout !== 1'b0) begin
               bad++;
               $display("FAIL idle case=%0d cyc=%0d: validout=%b, want 0", cur_id, cyc, validout);
            end
         end
      end
   end

   task automatic send(input int px, input bit v, input int expv);
      din     = 8'(px);
      validin = v;
      @(posedge clock);
      #1;
      if (v && expv >= 0) exp_q.push_back('{cyc, expv});
      validin = 1'b0;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      validin = 1'b0;
      exp_q.delete();
      hist.delete();
      #1;
      total++;
      if (dout !== 8'd0 || validout !== 1'b0) begin
         bad++;
         $display("FAIL reset_out case=%0d: dout=%0d validout=%b, want 0 0", cur_id, dout, validout);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   task automatic drain();
      repeat (4) send(0, 1'b0, -1);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain case=%0d: %0d outputs missing, want 0", cur_id, exp_q.size());
      end
   endtask

   task automatic run_vec(input vec_t t);
      int px;
      int e;
      cur_id = t.id;
      do_reset();
      for (int r = 0; r < t.nrows; r++) begin
         for (int c = 0; c < W; c++) begin
            px = t.rowv[r] + (t.ramp ? c * 30 : 0);
            e  = (r >= 4) ? t.expv[r-4] + (t.ramp ? c * 30 : 0) : -1;
            send(px, 1'b1, e);
            if (t.gap) send($urandom_range(0, 255), 1'b0, -1);
         end
      end
      drain();
   endtask

   // Reference: output for stream pixel k is the vertical 6/58/128/58/6 sum over rows k-4W..k, >>8
   function automatic int model(input int k);
      return (6 * (hist[k] + hist[k-4*W]) + 58 * (hist[k-W] + hist[k-3*W])
              + 128 * hist[k-2*W]) / 256;
   endfunction

   initial begin
      int px;
      cyc     = 0;
      total   = 0;
      bad     = 0;
      cur_id  = -1;
      mon_en  = 1'b0;
      din     = '0;
      validin = 1'b0;
      reset   = 1'b0;

      vecs[0] = '{0, 6, 1'b0, 1'b0, '{100, 100, 100, 100, 100, 100, 0, 0, 0}, '{100, 100, 0, 0, 0}};
      vecs[1] = '{1, 9, 1'b0, 1'b0, '{0, 0, 0, 0, 255, 0, 0, 0, 0}, '{5, 57, 127, 57, 5}};
      vecs[2] = '{2, 6, 1'b1, 1'b0, '{100, 100, 100, 100, 100, 100, 0, 0, 0}, '{100, 100, 0, 0, 0}};
      vecs[3] = '{3, 6, 1'b0, 1'b1, '{0, 0, 0, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
      vecs[4] = '{4, 6, 1'b0, 1'b0, '{255, 255, 255, 255, 255, 255, 0, 0, 0}, '{255, 255, 0, 0, 0}};

      do_reset();
      mon_en = 1'b1;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Asynchronous reset between edges while outputs are streaming
      cur_id = 5;
      do_reset();
      for (int k = 0; k < 5 * W + 3; k++) send(100, 1'b1, (k >= 4 * W) ? 100 : -1);
      total++;
      if (validout !== 1'b1) begin
         bad++;
         $display("FAIL pre_reset_valid: validout=%b, want 1", validout);
      end
      do_reset();
      for (int k = 0; k < 5 * W; k++) send(200, 1'b1, (k >= 4 * W) ? 200 : -1);
      drain();

      // Random pixels with random gaps against the reference model
      cur_id = 6;
      do_reset();
      for (int k = 0; k < 10 * W; k++) begin
         px = $urandom_range(0, 255);
         hist.push_back(px);
         send(px, 1'b1, (k >= 4 * W) ? model(k) : -1);
         if ($urandom_range(0, 2) == 0) send($urandom_range(0, 255), 1'b0, -1);
      end
      drain();

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
